// File: rtl/arb_pkg.sv
// Shared definitions for the arbitrating register mux: mode encodings and
// the rotating one-hot grant function.
package arb_pkg;

  localparam int unsigned ARB_RR     = 0;
  localparam int unsigned ARB_FIXED  = 1;
  localparam int unsigned ARB_MAX_CH = 32;
  localparam int unsigned ARB_MAX_CW = 5;

  typedef logic [ARB_MAX_CH-1:0] arb_vec_t;

  // First set bit of req[n-1:0], searching upward from start and wrapping at n.
  function automatic arb_vec_t arb_grant(input arb_vec_t req,
                                         input int unsigned n,
                                         input int unsigned start);
    arb_vec_t    g;
    logic        found;
    int unsigned idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < ARB_MAX_CH; i++) begin
      if (i < n) begin
        idx = start + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[ARB_MAX_CW-1:0]]) begin
          g[idx[ARB_MAX_CW-1:0]] = 1'b1;
          found                  = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant to the first requester at or
// above ptr (wrapping); all-zero when en is low or nothing requests.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned CW       = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CW-1:0]       ptr,
  input  logic                en,
  output logic [CHANNELS-1:0] grant
);

  arb_vec_t w_req_ext;
  arb_vec_t w_grant_full;

  assign w_req_ext    = arb_vec_t'(req);
  assign w_grant_full = arb_grant(w_req_ext, CHANNELS, 32'(ptr));
  assign grant        = en ? w_grant_full[CHANNELS-1:0] : '0;

  // Bits above CHANNELS are never set because the request is zero-extended.
  generate
    if (CHANNELS < ARB_MAX_CH) begin : g_unused
      logic w_unused_hi;
      assign w_unused_hi = |w_grant_full[ARB_MAX_CH-1:CHANNELS];
    end
  endgenerate

endmodule

// File: rtl/arb_mux_reg.sv
// N-channel arbitrating multiplexer with a registered output stage and
// valid/ready handshakes; round-robin or fixed-priority selection.
module arb_mux_reg
  import arb_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned MODE     = 0,
  localparam int unsigned CW       = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    r_out_data;
  logic [CW-1:0]       r_out_chan;
  logic                r_out_valid;
  logic [CW-1:0]       r_ptr;

  logic                w_load;
  logic [CW-1:0]       w_ptr_eff;
  logic [CHANNELS-1:0] w_grant;
  logic                w_xfer;
  logic [CW-1:0]       w_gidx;
  logic [WIDTH-1:0]    w_data;
  logic [CW-1:0]       w_ptr_next;

  // Accept only when the output slot is empty or being drained this cycle.
  assign w_load    = !r_out_valid || out_ready;
  assign w_ptr_eff = (MODE == ARB_FIXED) ? '0 : r_ptr;

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .req   (in_valid),
    .ptr   (w_ptr_eff),
    .en    (w_load & rst_n),
    .grant (w_grant)
  );

  assign in_ready = w_grant;
  assign w_xfer   = |w_grant;

  always_comb begin
    w_gidx = '0;
    w_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (w_grant[i]) begin
        w_gidx = CW'(i);
        w_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_next = (w_gidx == CW'(CHANNELS - 1)) ? '0 : w_gidx + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_out_data  <= w_data;
      r_out_chan  <= w_gidx;
      r_out_valid <= 1'b1;
      if (MODE == ARB_RR) r_ptr <= w_ptr_next;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule

// File: doc/arb_mux_reg.md
# arb_mux_reg

Parametrised, registered N-channel arbitrating multiplexer with valid/ready handshakes on every input and on the output. It succeeds the fixed 8-bit 2-to-1 select mux in the SIC-4 datapath and is used where several producers share one consumer, for example register-file read sources or memory-port requesters. Instead of an external select line, it arbitrates internally using round-robin or fixed-priority mode. The winning word and its channel index are captured in an output register.

## Interface
- WIDTH, 8: data word width in bits, ≥1.
- CHANNELS, 4: number of input channels, ≥2.
- MODE, 0: 0 selects round-robin; 1 selects fixed priority, where the lowest index wins.
- CW, $clog2(CHANNELS): derived channel-index width. It is local and not overridable.
- clk, input, 1: the only clock. All state updates on its rising edge.
- rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
- in_data, input, CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid, input, CHANNELS: per-channel request.
- in_ready, output, CHANNELS: per-channel accept. At most one bit is high at a time (one-hot or zero).
- out_data, output, WIDTH: registered selected word.
- out_chan, output, CW: registered index of the channel that supplied out_data.
- out_valid, output, 1: out_data and out_chan hold a word.
- out_ready, input, 1: the consumer accepts a word.

## Operation
- Load enable: load = !out_valid || out_ready.
- Grant: when load=1 and any in_valid bit is set, exactly one channel g is granted and in_ready[g]=1. All other in_ready bits are 0. When load=0, in_ready is all-zero.
- A transfer on channel i happens in any cycle where in_valid[i] && in_ready[i].
- Round-robin (MODE=0): the search starts at pointer ptr and ascends modulo CHANNELS. The first channel with valid set wins. On an input transfer from channel g, ptr is set to (g+1) mod CHANNELS. When no input transfer occurs, ptr holds.
- Fixed priority (MODE=1): the lowest-index valid channel wins. ptr is unused and held at 0.
- Capture: on an input transfer, out_data is set to the word from channel g, out_chan is set to g, and out_valid is set to 1.
- Drain: if out_valid && out_ready and no input transfer occurs in the same cycle, out_valid is set to 0. out_data and out_chan hold their last values.
- Simultaneous drain and capture: the new word replaces the old word in the same edge, and out_valid stays 1. This gives full throughput of one word per cycle.
- Stall: while out_valid=1 and out_ready=0, the output register, ptr, and all in_ready bits are frozen or zero. Inputs may change freely during a stall, because nothing is accepted.
- No combinational path exists from in_data to out_data.

## Timing
- Reset (rst_n=0 at an edge): out_valid=0, out_data=0, out_chan=0, ptr=0. in_ready is forced to 0 during reset cycles.
- Reset mid-operation: any held word is discarded without being presented. Arbitration restarts from channel 0 on the first cycle with rst_n=1.
- Latency: a word accepted at edge n appears on out_data with out_valid=1 in the cycle after edge n. This is one cycle of latency.
- in_ready is combinational from in_valid, out_valid, out_ready, and ptr. in_valid must not depend on in_ready.
- out_valid does not depend combinationally on out_ready.
- Wrap-around: when g = CHANNELS-1, ptr is set to 0.
- When no channel is valid, there is no grant and ptr is unchanged.

## Structure
- The shared package `arb_pkg` holds:
  - the MODE encodings (ARB_RR=0, ARB_FIXED=1);
  - a function that computes the one-hot grant from a request vector and a start index.
- A single sub-module `rr_arbiter` is natural. Its ports are req, ptr, en, and grant (one-hot), and it contains the rotate and priority-encode logic. The top level holds ptr, the output register, and the data mux.

## Test plan
- Reset: assert rst_n=0 for 3 cycles with all in_valid=1. Required: out_valid=0, in_ready=0000, out_chan=0. After release, the first grant goes to channel 0.
- Round-robin fairness: CHANNELS=4, all in_valid=1 continuously, out_ready=1, in_data[i]=8'hA0+i. Required: out_chan follows 0,1,2,3,0,1 and out_data follows A0,A1,A2,A3,A0, with one word per cycle.
- Sparse requests and wrap: only channels 1 and 3 are valid, with ptr=2. Required: channel 3 is granted first and ptr becomes 0. Channel 1 is granted next and ptr becomes 2.
- Backpressure: set out_ready=0 for 5 cycles while a word is held (out_chan=2, out_data=8'h5C). Required: in_ready=0000 and the output is stable for all 5 cycles. On the first cycle with out_ready=1, the next channel is captured in the same edge.
- Fixed priority: MODE=1, in_valid=1110, out_ready=1. Required: channel 1 wins every cycle and channels 2 and 3 are starved. When channel 1 drops, channel 2 wins.
- Reset mid-stream: assert rst_n=0 while out_valid=1 with out_data=8'h33. Required: at the next edge out_valid=0 and out_data=0, and no transfer is counted.
